// File: rtl/otbn_pkg.sv
// Shared OTBN constants and types used by the DMEM arbiter and its bench.
// Holds the widened-word geometry, the response-owner enum and the stall counter width.
package otbn_pkg;

  parameter int WLEN             = 256;
  parameter int ExtWLEN          = WLEN * 39 / 32;
  parameter int BaseWordsPerWLEN = WLEN / 32;

  localparam int DmemStallCntW = 16;

  typedef enum logic [1:0] {
    RespNone,
    RespLsuRd,
    RespHost,
    RespHostErr
  } otbn_dmem_resp_e;

  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/otbn_dmem_arb.sv
// DMEM arbiter, LSU over host; OTBN_DMEM_ARB_HOST_LOCKOUT_EN answers busy-time host requests with an error.
// Latency: request to DMEM same cycle, response returned one cycle later.
// Backpressure: host_gnt_o withheld while the LSU requests (and, in the default build, while busy_i).
module otbn_dmem_arb
  import otbn_pkg::*;
#(
  parameter int  DmemSizeByte  = 4096,
  localparam int DmemAddrWidth = vbits(DmemSizeByte)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        busy_i,

  input  logic                        lsu_req_i,
  input  logic                        lsu_write_i,
  input  logic [DmemAddrWidth-1:0]    lsu_addr_i,
  input  logic [ExtWLEN-1:0]          lsu_wdata_i,
  input  logic [ExtWLEN-1:0]          lsu_wmask_i,
  input  logic [BaseWordsPerWLEN-1:0] lsu_rmask_i,
  output logic [ExtWLEN-1:0]          lsu_rdata_o,
  output logic                        lsu_rvalid_o,
  output logic                        lsu_rerror_o,

  input  logic                        host_req_i,
  input  logic                        host_write_i,
  output logic                        host_gnt_o,
  input  logic [DmemAddrWidth-1:0]    host_addr_i,
  input  logic [ExtWLEN-1:0]          host_wdata_i,
  input  logic [ExtWLEN-1:0]          host_wmask_i,
  output logic [ExtWLEN-1:0]          host_rdata_o,
  output logic                        host_rvalid_o,
  output logic                        host_rerror_o,

  output logic                        dmem_req_o,
  output logic                        dmem_write_o,
  output logic [DmemAddrWidth-1:0]    dmem_addr_o,
  output logic [ExtWLEN-1:0]          dmem_wdata_o,
  output logic [ExtWLEN-1:0]          dmem_wmask_o,
  output logic [BaseWordsPerWLEN-1:0] dmem_rmask_o,
  input  logic [ExtWLEN-1:0]          dmem_rdata_i,
  input  logic                        dmem_rvalid_i,
  input  logic                        dmem_rerror_i,

  output logic [DmemStallCntW-1:0]    host_stall_cnt_o,
  output logic                        rvalid_unexp_err_o
);

  otbn_dmem_resp_e          resp_q, resp_d;
  logic                     host_wr_q, host_wr_d;
  logic [DmemStallCntW-1:0] stall_cnt_q, stall_cnt_d;
  logic                     unexp_err_q, unexp_err_d;
  logic                     host_reject;
  logic                     host_access;
  logic                     rvalid_expected;

`ifdef OTBN_DMEM_ARB_HOST_LOCKOUT_EN
  // Busy-time host requests are accepted but turned away before reaching DMEM.
  assign host_gnt_o  = host_req_i & ~lsu_req_i;
  assign host_reject = host_gnt_o & busy_i;
`else
  assign host_gnt_o  = host_req_i & ~lsu_req_i & ~busy_i;
  assign host_reject = 1'b0;
`endif

  assign host_access = host_gnt_o & ~host_reject;

  always_comb begin
    dmem_req_o   = lsu_req_i | host_access;
    dmem_write_o = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_wmask_o = '0;
    dmem_rmask_o = '0;
    if (lsu_req_i) begin
      dmem_write_o = lsu_write_i;
      dmem_addr_o  = lsu_addr_i;
      dmem_wdata_o = lsu_wdata_i;
      dmem_wmask_o = lsu_wmask_i;
      dmem_rmask_o = lsu_rmask_i;
    end else if (host_access) begin
      dmem_write_o = host_write_i;
      dmem_addr_o  = host_addr_i;
      dmem_wdata_o = host_wdata_i;
      dmem_wmask_o = host_wmask_i;
      dmem_rmask_o = {BaseWordsPerWLEN{1'b1}};
    end
  end

  always_comb begin
    resp_d    = RespNone;
    host_wr_d = host_access & host_write_i;
    if (lsu_req_i && !lsu_write_i) begin
      resp_d = RespLsuRd;
    end else if (host_access) begin
      resp_d = RespHost;
    end else if (host_reject) begin
      resp_d = RespHostErr;
    end

    rvalid_expected = (resp_q == RespLsuRd) || ((resp_q == RespHost) && !host_wr_q);
    unexp_err_d     = unexp_err_q | (dmem_rvalid_i & ~rvalid_expected);

    stall_cnt_d = stall_cnt_q;
    if (host_req_i && !host_gnt_o && (stall_cnt_q != {DmemStallCntW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(DmemStallCntW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_q      <= RespNone;
      host_wr_q   <= 1'b0;
      stall_cnt_q <= '0;
      unexp_err_q <= 1'b0;
    end else begin
      resp_q      <= resp_d;
      host_wr_q   <= host_wr_d;
      stall_cnt_q <= stall_cnt_d;
      unexp_err_q <= unexp_err_d;
    end
  end

  // Only the owner of the current response sees non-zero data; everything else is forced low.
  always_comb begin
    lsu_rdata_o   = '0;
    lsu_rvalid_o  = 1'b0;
    lsu_rerror_o  = 1'b0;
    host_rdata_o  = '0;
    host_rvalid_o = 1'b0;
    host_rerror_o = 1'b0;
    unique case (resp_q)
      RespLsuRd: begin
        lsu_rvalid_o = dmem_rvalid_i;
        lsu_rerror_o = dmem_rvalid_i & dmem_rerror_i;
        lsu_rdata_o  = dmem_rdata_i;
      end
      RespHost: begin
        host_rvalid_o = 1'b1;
        if (!host_wr_q) begin
          host_rdata_o  = dmem_rdata_i;
          host_rerror_o = dmem_rerror_i;
        end
      end
      RespHostErr: begin
        host_rvalid_o = 1'b1;
        host_rerror_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign host_stall_cnt_o   = stall_cnt_q;
  assign rvalid_unexp_err_o = unexp_err_q;

endmodule
